// File: rtl/counter_access_arbiter_if.sv
// Bus bundle between the counter access arbiter, its requesters and the shared counter port.
// The master modport is the arbiter's view; the slave modport is the requesters/counter side.
interface counter_access_arbiter_if #(
  parameter int NREQ = 4,
  parameter int BITS = 32
);
  logic [NREQ-1:0]      req_valid;
  logic [4*NREQ-1:0]    req_wstrb;
  logic [BITS*NREQ-1:0] req_wdata;
  logic [BITS*NREQ-1:0] req_adr;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_err;
  logic [BITS-1:0]      req_rdata;

  logic                 cnt_valid;
  logic [3:0]           cnt_wstrb;
  logic [BITS-1:0]      cnt_wdata;
  logic [BITS-1:0]      cnt_adr;
  logic                 cnt_ready;
  logic [BITS-1:0]      cnt_rdata;

  modport master (
    input  req_valid, req_wstrb, req_wdata, req_adr, cnt_ready, cnt_rdata,
    output req_ready, req_err, req_rdata, cnt_valid, cnt_wstrb, cnt_wdata, cnt_adr
  );

  modport slave (
    output req_valid, req_wstrb, req_wdata, req_adr, cnt_ready, cnt_rdata,
    input  req_ready, req_err, req_rdata, cnt_valid, cnt_wstrb, cnt_wdata, cnt_adr
  );
endinterface

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter sharing one counter valid/ready port among NREQ requesters.
// Optional wait timeout on the downstream handshake: define COUNTER_ARB_TIMEOUT_EN.
module counter_access_arbiter #(
  parameter int NREQ    = 4,
  parameter int BITS    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  counter_access_arbiter_if.master bus,
  output logic                     busy,
  output logic [2:0]               grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      last_q, last_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic [BITS-1:0] adr_q, adr_d;
  logic [BITS-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            win_found;
  logic [2:0]      win_idx;
  logic            timeout_hit;
  logic [NREQ-1:0] ready_vec;
  logic [NREQ-1:0] err_vec;

  // Scan starts just after the last served requester so it gets lowest priority next.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = 3'(idx);
      end
    end
  end

`ifdef COUNTER_ARB_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  // Counts ISSUE cycles that ended without cnt_ready; zero whenever not waiting.
  always_comb begin
    wait_d = '0;
    if (state_q == ISSUE && !bus.cnt_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // Firing on TIMEOUT-1 keeps cnt_valid high for exactly TIMEOUT cycles.
  assign timeout_hit = (wait_q == 8'(TIMEOUT - 1));
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    adr_d   = adr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          wstrb_d = bus.req_wstrb[int'(win_idx)*4 +: 4];
          wdata_d = bus.req_wdata[int'(win_idx)*BITS +: BITS];
          adr_d   = bus.req_adr[int'(win_idx)*BITS +: BITS];
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A ready pulse in the timeout cycle still completes normally.
        if (bus.cnt_ready) begin
          rdata_d = bus.cnt_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(NREQ - 1);
      wstrb_q <= '0;
      wdata_q <= '0;
      adr_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      adr_q   <= adr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Response strobes are decoded from state so reset removes them at once.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
      assign ready_vec[gi] = (state_q == RESP) && (grant_q == 3'(gi));
`ifdef COUNTER_ARB_TIMEOUT_EN
      assign err_vec[gi]   = ready_vec[gi] && err_q;
`else
      assign err_vec[gi]   = 1'b0;
`endif
    end
  endgenerate

`ifndef COUNTER_ARB_TIMEOUT_EN
  logic unused_err;

  assign unused_err = err_q;
`endif

  assign bus.req_ready = ready_vec;
  assign bus.req_err   = err_vec;
  assign bus.req_rdata = rdata_q;
  assign bus.cnt_valid = (state_q == ISSUE);
  assign bus.cnt_wstrb = wstrb_q;
  assign bus.cnt_wdata = wdata_q;
  assign bus.cnt_adr   = adr_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench for counter_access_arbiter: counter stub, response scoreboard, immediate assertions.
module tb_counter_access_arbiter;
  localparam int NREQ = 4;
  localparam int BITS = 32;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [2:0] grant_id;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];

  bit          stub_en = 1'b0;
  int          stub_delay = 0;
  int          stub_cnt = 0;
  logic [3:0]  prev_ready = '0;

  counter_access_arbiter_if #(.NREQ(NREQ), .BITS(BITS)) bus ();

  counter_access_arbiter #(.NREQ(NREQ), .BITS(BITS), .TIMEOUT(5)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.id = id; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [31:0] adr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    bus.req_adr[i*32 +: 32]  = adr;
    bus.req_wdata[i*32 +: 32] = wdata;
    bus.req_wstrb[i*4 +: 4]  = wstrb;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Waits for every expected response, then releases all requests and waits for IDLE.
  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    bus.req_valid = '0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(busy), 64'd1);
  endtask

  // Counter stub: answers a held cnt_valid after stub_delay cycles with rdata = adr + 0xA5.
  always @(negedge clk) begin
    if (bus.cnt_ready) begin
      bus.cnt_ready = 1'b0;
    end else if (stub_en && bus.cnt_valid) begin
      if (stub_cnt >= stub_delay) begin
        bus.cnt_ready = 1'b1;
        bus.cnt_rdata = bus.cnt_adr + 32'hA5;
        stub_cnt      = 0;
      end else begin
        stub_cnt++;
      end
    end else begin
      stub_cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.req_ready != '0) begin
      chk("ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
      chk("ready_pulse", 64'(prev_ready), 64'd0);
      chk("valid_after_ready", 64'(bus.cnt_valid), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'(bus.req_ready), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("ready_id", 64'(bus.req_ready), 64'(4'b0001 << e.id));
        chk("rdata", 64'(bus.req_rdata), 64'(e.rdata));
        chk("err", 64'(bus.req_err), 64'(e.err ? (4'b0001 << e.id) : 4'b0000));
        $display("txn: ready=%b err=%b rdata=%08h (expect id=%0d rdata=%08h err=%0d)",
                 bus.req_ready, bus.req_err, bus.req_rdata, e.id, e.rdata, e.err);
      end
    end
    prev_ready = bus.req_ready;
  end

  initial begin
    int n_hi;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_wstrb = '0;
    bus.req_wdata = '0;
    bus.req_adr   = '0;
    bus.cnt_ready = 1'b0;
    bus.cnt_rdata = '0;
    repeat (2) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt_valid", 64'(bus.cnt_valid), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rdata", 64'(bus.req_rdata), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    rst_n = 1'b1;

    // Single write from requester 0.
    stub_en = 1'b1; stub_delay = 2;
    set_req(0, 32'h0, 32'h12345678, 4'hF);
    push(0, 32'h000000A5, 1'b0);
    bus.req_valid = 4'b0001;
    chk("t1_valid_before", 64'(bus.cnt_valid), 64'd0);
    step();
    chk("t1_valid_lat1", 64'(bus.cnt_valid), 64'd1);
    chk("t1_wdata", 64'(bus.cnt_wdata), 64'h12345678);
    chk("t1_adr", 64'(bus.cnt_adr), 64'h0);
    chk("t1_wstrb", 64'(bus.cnt_wstrb), 64'hF);
    chk("t1_grant", 64'(grant_id), 64'd0);
    bus.req_valid = '0;
    drain("t1_done", 50);
    repeat (3) step();
    chk("t1_rdata_hold", 64'(bus.req_rdata), 64'hA5);

    // All four held from reset: 0,1,2,3,0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    stub_delay = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(32'h100 * (i + 1)), 32'(i), 4'(i + 1));
    push(0, 32'h1A5, 1'b0); push(1, 32'h2A5, 1'b0); push(2, 32'h3A5, 1'b0);
    push(3, 32'h4A5, 1'b0); push(0, 32'h1A5, 1'b0);
    bus.req_valid = 4'b1111;
    drain("t2_done", 100);

    // Fairness: after 2 is granted, 1 and 3 pending -> 3 then 1.
    push(2, 32'h3A5, 1'b0);
    bus.req_valid = 4'b0100;
    step();
    chk("t3_grant2", 64'(grant_id), 64'd2);
    push(3, 32'h4A5, 1'b0); push(1, 32'h2A5, 1'b0);
    bus.req_valid = 4'b1010;
    drain("t3_done", 100);

    // Requester 1 drops valid and changes wdata after grant.
    stub_delay = 3;
    set_req(1, 32'h0000_0040, 32'hCAFE_0001, 4'h3);
    push(1, 32'h0000_00E5, 1'b0);
    bus.req_valid = 4'b0010;
    step();
    chk("t4_grant1", 64'(grant_id), 64'd1);
    bus.req_valid = '0;
    set_req(1, 32'h0000_0080, 32'hDEAD_BEEF, 4'hC);
    step();
    chk("t4_wdata_latched", 64'(bus.cnt_wdata), 64'hCAFE_0001);
    chk("t4_adr_latched", 64'(bus.cnt_adr), 64'h40);
    drain("t4_done", 50);

    // Counter never answers.
    stub_en = 1'b0;
    bus.req_valid = 4'b0001;
`ifdef COUNTER_ARB_TIMEOUT_EN
    push(0, 32'h0, 1'b1);
    step();
    bus.req_valid = '0;
    n_hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cnt_valid) n_hi++;
      step();
    end
    chk("t5_valid_cycles", 64'(n_hi), 64'd5);
    chk("t5_busy_drop", 64'(busy), 64'd0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    bus.req_valid = 4'b0100;
    wait_busy("t6_grant");
    bus.req_valid = '0;
    step();
`else
    step();
    bus.req_valid = '0;
    n_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy) n_hi++;
      step();
    end
    chk("t5_busy_held", 64'(n_hi), 64'd1000);
`endif

    // Reset while waiting in ISSUE.
    chk("t6_in_issue", 64'(bus.cnt_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 64'(bus.cnt_valid), 64'd0);
    chk("t6_busy_async", 64'(busy), 64'd0);
    step();
    stub_en = 1'b1; stub_delay = 1;
    set_req(0, 32'h10, 32'h1, 4'h1);
    set_req(3, 32'h30, 32'h3, 4'h8);
    push(0, 32'hB5, 1'b0); push(3, 32'hD5, 1'b0);
    bus.req_valid = 4'b1001;
    rst_n = 1'b1;
    step();
    chk("t6_first_grant", 64'(grant_id), 64'd0);
    drain("t6_done", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
